// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, IF/ID register and
// the decode-side stall/redirect controls.
interface fetch_stage_if;
  logic        cpu_en;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        id_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic [31:0] if_inst;

  modport master (
    input  cpu_en, inst_data, id_stall, redirect_en, redirect_pc,
    output inst_ren, inst_addr, if_valid, if_pc, if_pc_next, if_inst
  );

  modport slave (
    output cpu_en, inst_data, id_stall, redirect_en, redirect_pc,
    input  inst_ren, inst_addr, if_valid, if_pc, if_pc_next, if_inst
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, drives a 1-cycle-latency instruction memory and
// feeds the IF/ID register, with a 1-entry hold buffer for decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          cpu_rst,
  fetch_stage_if.master bus
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_reg;
  logic        req_reg;
  logic [31:0] req_pc_reg;
  logic        hold_valid_reg;
  logic [31:0] hold_pc_reg;
  logic [31:0] hold_inst_reg;
  logic        if_valid_reg;
  logic [31:0] if_pc_reg;
  logic [31:0] if_pc_next_reg;
  logic [31:0] if_inst_reg;

  logic [31:0] redirect_target;
  logic [31:0] fetch_addr;
  logic        fetch_en;
  logic        advance;

  assign redirect_target = bus.redirect_pc & WORD_MASK;
  assign fetch_addr      = bus.redirect_en ? redirect_target : pc_reg;
  // A redirect must issue even while decode is stalled, or the target is lost.
  assign fetch_en        = bus.cpu_en & ~cpu_rst & (bus.redirect_en | ~bus.id_stall);
  assign advance         = bus.cpu_en & ~bus.id_stall;

  assign bus.inst_ren    = fetch_en;
  assign bus.inst_addr   = fetch_addr & WORD_MASK;
  assign bus.if_valid    = if_valid_reg;
  assign bus.if_pc       = if_pc_reg;
  assign bus.if_pc_next  = if_pc_next_reg;
  assign bus.if_inst     = if_inst_reg;

  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc_reg         <= RESET_PC & WORD_MASK;
      req_reg        <= 1'b0;
      req_pc_reg     <= 32'h0;
      hold_valid_reg <= 1'b0;
      hold_pc_reg    <= 32'h0;
      hold_inst_reg  <= NOP_INST;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= 32'h0;
      if_pc_next_reg <= 32'h0;
      if_inst_reg    <= NOP_INST;
    end else begin
      if (fetch_en)
        pc_reg <= fetch_addr + 32'd4;
      else if (bus.redirect_en)
        pc_reg <= redirect_target;

      req_reg    <= fetch_en;
      req_pc_reg <= fetch_addr;

      if (bus.redirect_en) begin
        // Flush: the in-flight response and any held word belong to the old path.
        if_valid_reg   <= 1'b0;
        if_inst_reg    <= NOP_INST;
        hold_valid_reg <= 1'b0;
      end else if (advance) begin
        if (hold_valid_reg) begin
          if_valid_reg   <= 1'b1;
          if_pc_reg      <= hold_pc_reg;
          if_pc_next_reg <= hold_pc_reg + 32'd4;
          if_inst_reg    <= hold_inst_reg;
          hold_valid_reg <= 1'b0;
        end else if (req_reg) begin
          if_valid_reg   <= 1'b1;
          if_pc_reg      <= req_pc_reg;
          if_pc_next_reg <= req_pc_reg + 32'd4;
          if_inst_reg    <= bus.inst_data;
        end else begin
          if_valid_reg   <= 1'b0;
          if_inst_reg    <= NOP_INST;
        end
      end else if (req_reg) begin
        // Memory data is only on the bus for one cycle; park it until decode frees up.
        hold_valid_reg <= 1'b1;
        hold_pc_reg    <= req_pc_reg;
        hold_inst_reg  <= bus.inst_data;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios then random stall/enable/redirect/reset
// traffic, scored against a FIFO-of-outstanding-fetches reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int unsigned issued;
  } fetch_t;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic cpu_rst;
  int   checks   = 0;
  int   failures = 0;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk     (clk),
    .cpu_rst (cpu_rst),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    if (bus.inst_ren)
      bus.inst_data <= mem_word(bus.inst_addr);
  end

  // Reference model: every issued fetch joins a FIFO and leaves it, in order,
  // at the first advancing edge after its data returns; a redirect empties it.
  fetch_t      fq[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int unsigned cyc = 0;
  logic        cur_valid = 1'b0;
  logic [31:0] cur_pc = 32'h0;
  logic [31:0] cur_inst = NOP_INST;

  always @(posedge clk) begin : ref_model
    fetch_t      f;
    exp_t        e;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] tgt;
    tgt = bus.redirect_pc & 32'hFFFF_FFFC;
    if (cpu_rst) begin
      model_pc  = RESET_PC;
      fq.delete();
      cur_valid = 1'b0;
      cur_pc    = 32'h0;
      cur_inst  = NOP_INST;
    end else begin
      ren  = bus.cpu_en && (bus.redirect_en || !bus.id_stall);
      addr = bus.redirect_en ? tgt : model_pc;
      if (bus.redirect_en) begin
        fq.delete();
        cur_valid = 1'b0;
        cur_inst  = NOP_INST;
      end else if (bus.cpu_en && !bus.id_stall) begin
        if (fq.size() > 0 && fq[0].issued < cyc) begin
          f         = fq.pop_front();
          cur_valid = 1'b1;
          cur_pc    = f.pc;
          cur_inst  = f.inst;
        end else begin
          cur_valid = 1'b0;
          cur_inst  = NOP_INST;
        end
      end
      if (ren) begin
        f.pc     = addr;
        f.inst   = mem_word(addr);
        f.issued = cyc;
        fq.push_back(f);
        model_pc = addr + 32'd4;
      end else if (bus.redirect_en) begin
        model_pc = tgt;
      end
    end
    e.rst   = cpu_rst;
    e.valid = cur_valid;
    e.pc    = cur_pc;
    e.inst  = cur_inst;
    exp_q.push_back(e);
    cyc++;
  end

  // Monitor: one expected IF/ID snapshot per edge, compared just after the edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("if_valid", 32'(bus.if_valid), 32'(e.valid));
      chk("if_inst", bus.if_inst, e.inst);
      if (e.rst) begin
        chk("if_pc_rst", bus.if_pc, 32'h0);
        chk("if_pc_next_rst", bus.if_pc_next, 32'h0);
      end else if (e.valid) begin
        chk("if_pc", bus.if_pc, e.pc);
        chk("if_pc_next", bus.if_pc_next, e.pc + 32'd4);
      end
    end
    chk("hold_req_exclusive", 32'(dut.hold_valid_reg & dut.req_reg), 32'd0);
  end

  // Request port is combinational; check it mid-cycle with inputs settled.
  always @(negedge clk) begin : req_checker
    logic exp_ren;
    exp_ren = bus.cpu_en && !cpu_rst && (bus.redirect_en || !bus.id_stall);
    chk("inst_ren", 32'(bus.inst_ren), 32'(exp_ren));
    if (exp_ren)
      chk("inst_addr", bus.inst_addr,
          bus.redirect_en ? (bus.redirect_pc & 32'hFFFF_FFFC) : model_pc);
  end

  task automatic set_in(input logic st, input logic en, input logic rd, input logic [31:0] rp);
    bus.id_stall    = st;
    bus.cpu_en      = en;
    bus.redirect_en = rd;
    bus.redirect_pc = rp;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    cpu_rst = 1'b1;
    bus.inst_data = 32'h0;
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    #3;
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_pc_next", bus.if_pc_next, 32'h0);
    chk("rst_if_inst", bus.if_inst, NOP_INST);
    chk("rst_inst_ren", 32'(bus.inst_ren), 32'd0);
    @(posedge clk);
    #2;
    cpu_rst = 1'b0;

    // Startup: first valid instruction two edges after reset release.
    step();
    chk("start_edge1_valid", 32'(bus.if_valid), 32'd0);
    step();
    chk("start_edge2_valid", 32'(bus.if_valid), 32'd1);
    chk("start_edge2_pc", bus.if_pc, 32'h0);
    chk("start_edge2_inst", bus.if_inst, 32'h1000_0000);
    chk("start_edge2_pc_next", bus.if_pc_next, 32'h4);
    step();
    step();
    chk("start_edge4_pc", bus.if_pc, 32'h8);

    // Three-cycle decode stall while pc 8 is presented.
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc_hold", bus.if_pc, 32'h8);
      chk("stall_valid_hold", 32'(bus.if_valid), 32'd1);
    end
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("release_hold_pc", bus.if_pc, 32'hC);
    chk("release_hold_inst", bus.if_inst, 32'h1000_000C);
    step();

    // Redirect overriding a stall; target low bits ignored.
    set_in(1'b1, 1'b1, 1'b1, 32'h0000_0043);
    #1;
    chk("redir_addr", bus.inst_addr, 32'h40);
    chk("redir_ren", 32'(bus.inst_ren), 32'd1);
    step();
    chk("redir_bubble", 32'(bus.if_valid), 32'd0);
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("redir_target_valid", 32'(bus.if_valid), 32'd1);
    chk("redir_target_pc", bus.if_pc, 32'h40);
    step();
    step();

    // Fill the hold buffer, then redirect in the very next cycle.
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    set_in(1'b0, 1'b1, 1'b1, 32'h40);
    step();
    chk("flush_hold_bubble", 32'(bus.if_valid), 32'd0);
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("flush_hold_pc0", bus.if_pc, 32'h40);
    step();
    chk("flush_hold_pc1", bus.if_pc, 32'h44);

    // Asynchronous reset between edges.
    cpu_rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.if_valid), 32'd0);
    chk("async_rst_inst", bus.if_inst, NOP_INST);
    chk("async_rst_ren", 32'(bus.inst_ren), 32'd0);
    step();
    cpu_rst = 1'b0;
    step();
    step();
    chk("restart_pc", bus.if_pc, RESET_PC);
    chk("restart_valid", 32'(bus.if_valid), 32'd1);

    // Disabled redirect to the top word, then wrap to zero after re-enable.
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    #1;
    chk("dis_redir_ren", 32'(bus.inst_ren), 32'd0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("wrap_addr_top", bus.inst_addr, 32'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_addr_zero", bus.inst_addr, 32'h0);
    step();
    chk("wrap_pc_top", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_next_top", bus.if_pc_next, 32'h0);
    step();
    chk("wrap_pc_zero", bus.if_pc, 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 255));
      set_in($urandom_range(0, 99) < 25, $urandom_range(0, 9) != 0,
             $urandom_range(0, 9) == 0, rp);
      cpu_rst = ($urandom_range(0, 199) == 0);
      step();
    end
    cpu_rst = 1'b0;
    set_in(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
